// File: rtl/mips_defs.sv
// Shared definitions for the MIPS fetch stage: halt opcode, NOP word, IF FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_defs;

    localparam int          LEN         = 32;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a synchronous write port and a combinational read port.
// Latency: write lands at the clock edge; read data follows raddr_i in the same cycle.
// Backpressure: none, always accepts a write when we_i is high.
module instruction_memory #(
    parameter int WIDTH   = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [NB_ADDR-1:0] waddr_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic [NB_ADDR-1:0] raddr_i,
    output logic [WIDTH-1:0]   rdata_o
);

    localparam int DEPTH = 1 << NB_ADDR;

    // No reset: the loaded program survives a pipeline reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction memory with debug load port, IF/ID register, IDLE/RUN/HALTED control.
// Latency: fetched word appears in IF/ID one edge after its PC; a redirect costs one bubble.
// Backpressure: in_stall freezes PC and IF/ID; in_pc_src overrides stall and flushes IF/ID.
module instruction_fetch
    import mips_defs::*;
#(
    parameter int         len         = LEN,
    parameter int         NB_ADDR     = 10,
    parameter logic [5:0] HALT_OPCODE = mips_defs::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_start,
    input  logic               in_load_en,
    input  logic [NB_ADDR-1:0] in_load_addr,
    input  logic [len-1:0]     in_load_data,
    input  logic               in_stall,
    input  logic               in_pc_src,
    input  logic [len-1:0]     in_pc_jump,
    output logic [len-1:0]     out_pc_jump,
    output logic [len-1:0]     out_instruccion,
    output logic               out_valid,
    output logic [len-1:0]     out_pc,
    output logic               out_halt
);

    localparam logic [len-1:0] ALIGN_MASK = {{(len-2){1'b1}}, 2'b00};

    if_state_t      state_q;
    logic [len-1:0] pc_q;
    logic [len-1:0] ifid_instr_q;
    logic [len-1:0] ifid_pcj_q;
    logic           ifid_vld_q;
    logic           halt_q;

    logic [len-1:0] imem_rdata;
    logic [len-1:0] pc_plus4_d;
    logic           imem_we;
    logic           is_halt_d;

    // Loads are only honoured while idle and out of reset, so stray strobes never corrupt the program.
    assign imem_we    = reset && (state_q == ST_IDLE) && in_load_en;
    assign pc_plus4_d = pc_q + len'(4);
    assign is_halt_d  = (imem_rdata[len-1:len-6] == HALT_OPCODE);

    instruction_memory #(
        .WIDTH   (len),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .clk     (clk),
        .we_i    (imem_we),
        .waddr_i (in_load_addr),
        .wdata_i (in_load_data),
        .raddr_i (pc_q[NB_ADDR+1:2]),
        .rdata_o (imem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ifid_instr_q <= len'(NOP_WORD);
            ifid_pcj_q   <= '0;
            ifid_vld_q   <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pc_q         <= '0;
                    ifid_instr_q <= len'(NOP_WORD);
                    ifid_pcj_q   <= '0;
                    ifid_vld_q   <= 1'b0;
                    if (in_start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_pc_src) begin
                        pc_q         <= in_pc_jump & ALIGN_MASK;
                        ifid_instr_q <= len'(NOP_WORD);
                        ifid_pcj_q   <= '0;
                        ifid_vld_q   <= 1'b0;
                    end else if (!in_stall) begin
                        ifid_instr_q <= imem_rdata;
                        ifid_pcj_q   <= pc_plus4_d;
                        ifid_vld_q   <= 1'b1;
                        // The halt word is delivered downstream, but the PC parks on it.
                        if (is_halt_d) begin
                            state_q <= ST_HALTED;
                            halt_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4_d;
                        end
                    end
                end
                ST_HALTED: begin
                    ifid_instr_q <= len'(NOP_WORD);
                    ifid_pcj_q   <= '0;
                    ifid_vld_q   <= 1'b0;
                    halt_q       <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_pc_jump     = ifid_pcj_q;
    assign out_instruccion = ifid_instr_q;
    assign out_valid       = ifid_vld_q;
    assign out_pc          = pc_q;
    assign out_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for the IF stage: load, run, stall, redirect, halt, reset/restart.
// Latency: n/a.  Backpressure: n/a.
module tb_instruction_fetch;

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'h2002_0007;
    localparam logic [31:0] W2 = 32'h0022_1820;
    localparam logic [31:0] WH = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_start;
    logic        in_load_en;
    logic [9:0]  in_load_addr;
    logic [31:0] in_load_data;
    logic        in_stall;
    logic        in_pc_src;
    logic [31:0] in_pc_jump;
    logic [31:0] out_pc_jump;
    logic [31:0] out_instruccion;
    logic        out_valid;
    logic [31:0] out_pc;
    logic        out_halt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .in_start        (in_start),
        .in_load_en      (in_load_en),
        .in_load_addr    (in_load_addr),
        .in_load_data    (in_load_data),
        .in_stall        (in_stall),
        .in_pc_src       (in_pc_src),
        .in_pc_jump      (in_pc_jump),
        .out_pc_jump     (out_pc_jump),
        .out_instruccion (out_instruccion),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_halt        (out_halt)
    );

    typedef struct {
        logic        start;
        logic        load_en;
        logic [9:0]  load_addr;
        logic [31:0] load_data;
        logic        stall;
        logic        pc_src;
        logic [31:0] pc_jump;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcj;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic        exp_halt;
    } vec_t;

    function automatic vec_t mk(logic st, logic ld, logic [9:0] la, logic [31:0] lw,
                                logic sl, logic ps, logic [31:0] pj,
                                logic [31:0] ei, logic [31:0] ej, logic ev,
                                logic [31:0] ep, logic eh);
        vec_t v;
        v.start = st; v.load_en = ld; v.load_addr = la; v.load_data = lw;
        v.stall = sl; v.pc_src = ps; v.pc_jump = pj;
        v.exp_instr = ei; v.exp_pcj = ej; v.exp_vld = ev; v.exp_pc = ep; v.exp_halt = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] ei, input logic [31:0] ej,
                            input logic ev, input logic [31:0] ep, input logic eh);
        chk({tag, ".instr"}, out_instruccion, ei);
        chk({tag, ".pcj"},   out_pc_jump,     ej);
        chk({tag, ".valid"}, 32'(out_valid),  32'(ev));
        chk({tag, ".pc"},    out_pc,          ep);
        chk({tag, ".halt"},  32'(out_halt),   32'(eh));
    endtask

    task automatic step(input vec_t v, input string tag);
        in_start     = v.start;
        in_load_en   = v.load_en;
        in_load_addr = v.load_addr;
        in_load_data = v.load_data;
        in_stall     = v.stall;
        in_pc_src    = v.pc_src;
        in_pc_jump   = v.pc_jump;
        @(posedge clk);
        #1;
        chk_outs(tag, v.exp_instr, v.exp_pcj, v.exp_vld, v.exp_pc, v.exp_halt);
    endtask

    task automatic idle_inputs();
        in_start = 0; in_load_en = 0; in_load_addr = '0; in_load_data = '0;
        in_stall = 0; in_pc_src = 0; in_pc_jump = '0;
    endtask

    vec_t main_vecs[15];
    vec_t restart_vecs[4];

    initial begin
        // Load program, start on the last write, run, stall, redirect, halt.
        main_vecs[0]  = mk(0,1,10'd0,W0,          0,0,32'h0,  32'h0,32'h0,0,32'h0,0);
        main_vecs[1]  = mk(0,1,10'd1,W1,          0,0,32'h0,  32'h0,32'h0,0,32'h0,0);
        main_vecs[2]  = mk(0,1,10'd2,W2,          0,0,32'h0,  32'h0,32'h0,0,32'h0,0);
        main_vecs[3]  = mk(1,1,10'd3,WH,          0,0,32'h0,  32'h0,32'h0,0,32'h0,0);
        main_vecs[4]  = mk(0,1,10'd2,32'hDEADBEEF,0,0,32'h0,  W0,32'd4,1,32'd4,0);
        main_vecs[5]  = mk(0,0,10'd0,32'h0,       0,0,32'h0,  W1,32'd8,1,32'd8,0);
        main_vecs[6]  = mk(0,0,10'd0,32'h0,       1,0,32'h0,  W1,32'd8,1,32'd8,0);
        main_vecs[7]  = mk(0,0,10'd0,32'h0,       1,0,32'h0,  W1,32'd8,1,32'd8,0);
        main_vecs[8]  = mk(0,0,10'd0,32'h0,       0,0,32'h0,  W2,32'd12,1,32'd12,0);
        main_vecs[9]  = mk(0,0,10'd0,32'h0,       1,1,32'h6,  32'h0,32'h0,0,32'd4,0);
        main_vecs[10] = mk(0,0,10'd0,32'h0,       0,0,32'h0,  W1,32'd8,1,32'd8,0);
        main_vecs[11] = mk(0,0,10'd0,32'h0,       0,0,32'h0,  W2,32'd12,1,32'd12,0);
        main_vecs[12] = mk(0,0,10'd0,32'h0,       0,0,32'h0,  WH,32'd16,1,32'd12,1);
        main_vecs[13] = mk(1,1,10'd0,32'h12345678,1,1,32'h40, 32'h0,32'h0,0,32'd12,1);
        main_vecs[14] = mk(1,0,10'd0,32'h0,       0,1,32'h80, 32'h0,32'h0,0,32'd12,1);

        // Restart after reset: program retained, redirect address wraps modulo depth.
        restart_vecs[0] = mk(1,0,10'd0,32'h0,0,0,32'h0,        32'h0,32'h0,0,32'h0,0);
        restart_vecs[1] = mk(0,0,10'd0,32'h0,0,0,32'h0,        W0,32'd4,1,32'd4,0);
        restart_vecs[2] = mk(0,0,10'd0,32'h0,0,1,32'h1000_000B,32'h0,32'h0,0,32'h1000_0008,0);
        restart_vecs[3] = mk(0,0,10'd0,32'h0,0,0,32'h0,        W2,32'h1000_000C,1,32'h1000_000C,0);

        // Reset held with random inputs.
        reset        = 1'b0;
        in_start     = 1'($urandom);
        in_load_en   = 1'($urandom);
        in_load_addr = 10'($urandom);
        in_load_data = $urandom;
        in_stall     = 1'($urandom);
        in_pc_src    = 1'($urandom);
        in_pc_jump   = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset_hold", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("idle_nostart", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(main_vecs[i], $sformatf("main%0d", i));
        end

        // Asynchronous reset while halted, no clock edge in between.
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        chk_outs("rst_halted", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step(restart_vecs[i], $sformatf("restart%0d", i));
        end

        // Asynchronous reset mid-run.
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        chk_outs("rst_run", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        step(mk(1,0,10'd0,32'h0,0,0,32'h0, 32'h0,32'h0,0,32'h0,0), "rerun0");
        step(mk(0,0,10'd0,32'h0,0,0,32'h0, W0,32'd4,1,32'd4,0),    "rerun1");
        step(mk(0,0,10'd0,32'h0,0,0,32'h0, W1,32'd8,1,32'd8,0),    "rerun2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Holds the PC and a word-addressed instruction memory with a debug load port.
- Drives the IF/ID pipeline register that feeds decode's in_pc_jump / in_instruccion.
- Handles stall from hazard logic, redirect from branch/jump resolution, and halt detection.

Parameters:
- len, 32, datapath / PC / instruction width
- NB_ADDR, 10, imem address bits (depth 2^NB_ADDR words)
- HALT_OPCODE, 6'b111111, opcode that stops fetch

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_start  input  1  IDLE->RUN request
- in_load_en  input  1  imem write strobe (honoured in IDLE only)
- in_load_addr  input  NB_ADDR  imem word address for load
- in_load_data  input  len  imem word to write
- in_stall  input  1  hold PC and IF/ID (load-use hazard)
- in_pc_src  input  1  redirect PC (taken branch/jump)
- in_pc_jump  input  len  redirect target byte address
- out_pc_jump  output  len  PC+4 of the instruction in IF/ID
- out_instruccion  output  len  instruction in IF/ID
- out_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- out_pc  output  len  current fetch PC (debug)
- out_halt  output  1  high while in HALTED

Behaviour:
- Reset (async, reset=0):
  - PC=0; state=IDLE.
  - out_pc_jump=0, out_instruccion=0 (NOP), out_valid=0, out_halt=0.
  - imem contents are not cleared.
- imem:
  - Write: synchronous.
  - Read: combinational at index PC[NB_ADDR+1:2]. Higher PC bits are ignored, so addresses wrap modulo depth.
- States:
  - IDLE:
    - in_load_en=1 writes in_load_data to imem[in_load_addr] at the edge.
    - PC holds 0; IF/ID holds NOP with valid=0.
    - in_start=1 -> RUN next edge. If in_load_en and in_start are both high, the write completes and RUN is entered.
  - RUN, per edge, priority in_pc_src > in_stall > normal:
    - in_pc_src=1: PC <= {in_pc_jump[len-1:2],2'b00}; IF/ID <= NOP, valid=0 (flush of the wrong-path fetch). Applies even if in_stall=1.
    - in_stall=1 (no pc_src): PC and IF/ID unchanged.
    - normal: PC <= PC+4 (mod 2^len); IF/ID <= {imem[PC], PC+4}, valid=1.
    - When a normal load latches an instruction with [31:26]==HALT_OPCODE, the halt word goes into IF/ID with valid=1 and state -> HALTED. PC stays at the halt address.
    - in_load_en is ignored.
  - HALTED:
    - PC frozen; out_halt=1.
    - One edge after entry, IF/ID <= NOP, valid=0, and holds there.
    - in_start, in_stall, in_pc_src and in_load_en are ignored. Exit only via reset.
- Latency:
  - Instruction at PC appears on out_instruccion 1 cycle after it is addressed.
  - Redirect target's instruction appears 2 edges after in_pc_src is sampled (one bubble).
- out_pc is the live PC register value.
- Reset mid-RUN or in HALTED: immediate return to IDLE and reset values. Program in imem is retained.

Decomposition:
- Shared package/header (mips_defs): HALT_OPCODE, NOP word (32'h0), FSM state encodings (IDLE=2'd0, RUN=2'd1, HALTED=2'd2), len default.
- One sub-module: instruction_memory (sync write, async read, parameterised width/depth).
- PC, FSM and IF/ID register stay in instruction_fetch.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, out_valid=0. Release, no start -> outputs stay 0.
- Load and run:
  - Load imem[0..2]=32'h20010005, 32'h20020007, 32'h00221820, then pulse in_start.
  - -> out_instruccion shows the three words on consecutive cycles; out_pc_jump=4,8,12; out_valid=1.
- Stall: assert in_stall 2 cycles while word1 is in IF/ID -> out_instruccion=32'h20020007 and out_pc=8 held for 2 cycles; fetch then resumes with 32'h00221820.
- Redirect:
  - in_pc_src=1, in_pc_jump=32'h0000_0006 with in_stall=1 same cycle.
  - -> next cycle valid=0 and instruction=0; PC=4; following cycle instruction=imem[1], out_pc_jump=8.
- Halt:
  - imem[3]=32'hFC000000.
  - -> after it appears with valid=1: out_halt=1, PC stays 12, then valid=0; in_start/in_pc_src ignored.
- Reset during RUN then restart:
  - Assert reset mid-run -> outputs 0 asynchronously, state IDLE.
  - in_start -> program re-executes from PC=0 with the same imem contents.
